// File: rtl/pipelined_exec_core.sv
// ID/EXE/WB execution pipeline with register file, ALU and EXE/WB->ID operand forwarding.
// Result reaches wb_* two cycles after issue and the register file one cycle later; hold freezes every stage.
module pipelined_exec_core #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int FWD_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              in_valid,
  input  logic [2:0]        in_aluop,
  input  logic              in_alusrc,
  input  logic [ADDR_W-1:0] in_raddr1,
  input  logic [ADDR_W-1:0] in_raddr2,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic              in_wen,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] aluout,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int NREGS = 2**ADDR_W;
  localparam int SH_W  = $clog2(DATA_W);

  logic [DATA_W-1:0] regs [NREGS];

  logic              ex_valid;
  logic              ex_wen;
  logic [2:0]        ex_aluop;
  logic [ADDR_W-1:0] ex_waddr;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic              wb_wen;

  logic [ADDR_W-1:0] src_addr [2];
  logic [DATA_W-1:0] src_val  [2];
  logic [DATA_W-1:0] op_b;
  logic              wr_en;

  assign src_addr[0] = in_raddr1;
  assign src_addr[1] = in_raddr2;

  // EXE result is newer than WB, so it is checked last and wins.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      src_val[i] = regs[src_addr[i]];
      if (FWD_EN != 0) begin
        if (wb_valid && wb_wen && (wb_waddr == src_addr[i])) src_val[i] = wb_data;
        if (ex_valid && ex_wen && (ex_waddr == src_addr[i])) src_val[i] = aluout;
      end
      if ((ZERO_REG != 0) && (src_addr[i] == '0)) src_val[i] = '0;
    end
  end

  assign op_b = in_alusrc ? in_imm : src_val[1];

  always_comb begin
    aluout = '0;
    case (ex_aluop)
      3'b000: aluout = ex_a + ex_b;
      3'b001: aluout = ex_a - ex_b;
      3'b010: aluout = ex_a & ex_b;
      3'b011: aluout = ex_a | ex_b;
      3'b100: aluout = ex_a ^ ex_b;
      3'b101: aluout = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
      3'b110: aluout = ex_a << ex_b[SH_W-1:0];
      3'b111: aluout = ex_a >> ex_b[SH_W-1:0];
      default: aluout = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid  <= 1'b0;
      ex_wen    <= 1'b0;
      ex_aluop  <= '0;
      ex_waddr  <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      wb_valid  <= 1'b0;
      wb_wen    <= 1'b0;
      wb_waddr  <= '0;
      wb_data   <= '0;
      zero_flag <= 1'b0;
    end else if (!hold) begin
      ex_valid  <= in_valid;
      ex_wen    <= in_wen;
      ex_aluop  <= in_aluop;
      ex_waddr  <= in_waddr;
      ex_a      <= src_val[0];
      ex_b      <= op_b;
      wb_valid  <= ex_valid;
      wb_wen    <= ex_wen;
      wb_waddr  <= ex_waddr;
      wb_data   <= aluout;
      zero_flag <= ex_valid && (aluout == '0);
    end
  end

  assign wr_en = wb_valid && wb_wen && !hold && !((ZERO_REG != 0) && (wb_waddr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wb_waddr] <= wb_data;
    end
  end

  assign dbg_rdata = regs[dbg_raddr];

endmodule

// File: doc/pipelined_exec_core.md
Name: pipelined_exec_core

Overview:
Parametrised successor to the 4-stage pipelined register-file/ALU datapath. It takes pre-decoded instructions through a valid/hold interface and runs them through three internal stages: ID (register read, bypass mux, immediate select), EXE (ALU) and WB (register-file write). New relative to the fixed 32-bit version:
- configurable data width and register count;
- EXE->ID and WB->ID operand forwarding, switchable by parameter;
- pipeline hold;
- hard-wired zero register;
- debug read port.
It sits between the decode/issue logic and the memory/status logic of the CPU.

Parameters:
DATA_W, 32, datapath and register width.
ADDR_W, 5, register address width; NREGS = 2**ADDR_W.
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes.
FWD_EN, 1, 1 = forwarding enabled; 0 = no bypass, so software must insert bubbles.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
hold  in  1  freezes all pipeline registers and register-file writes.
in_valid  in  1  instruction present this cycle.
in_aluop  in  3  ALU operation code.
in_alusrc  in  1  0 = operand B is rdata2; 1 = operand B is in_imm.
in_raddr1  in  ADDR_W  source register A.
in_raddr2  in  ADDR_W  source register B.
in_waddr  in  ADDR_W  destination register.
in_wen  in  1  instruction writes the register file.
in_imm  in  DATA_W  sign-extended immediate.
aluout  out  DATA_W  combinational ALU result of the EXE stage.
wb_valid  out  1  valid bit of the WB stage (EXE/WB register).
wb_waddr  out  ADDR_W  destination address in the WB stage.
wb_data  out  DATA_W  result in the WB stage.
zero_flag  out  1  registered; set when the WB-stage result is 0.
dbg_raddr  in  ADDR_W  debug read address.
dbg_rdata  out  DATA_W  combinational register-file read, no bypass.

Behaviour:
Reset and hold:
- rst low (asynchronous): all ID/EXE and EXE/WB registers clear, valid bits go to 0, all NREGS registers clear to 0.
- Outputs after reset: wb_valid=0, wb_waddr=0, wb_data=0, zero_flag=0, aluout=0.
- Reset asserted mid-operation discards every in-flight instruction. Nothing is written after rst goes low.
- hold=1: every stage register and the register file keep their values. in_valid is ignored (the instruction is not accepted); the issuer must re-present it.
- rst has priority over hold.

Timing (instruction presented with in_valid=1, hold=0, in cycle k):
- Operands are read and bypassed in cycle k and captured into ID/EXE at the end of cycle k.
- ALU operates in cycle k+1; EXE/WB is captured at the end of cycle k+1.
- Register-file write occurs at the end of cycle k+2, only if wb_valid=1 and wen=1.
- An instruction issued in cycle k+3 reads the new value directly from the register file.
- in_valid=0 inserts a bubble: valid=0, and the bubble never writes.

Forwarding (FWD_EN=1), applied to each source independently:
- If the EXE-stage instruction is valid, has wen=1 and its waddr equals the source address, use aluout.
- Otherwise, if the WB stage is valid, has wen=1 and its waddr equals the source address, use wb_data.
- Otherwise, use the register-file read.
- EXE has priority over WB.
- With ZERO_REG=1, address 0 is never forwarded and always reads 0.
- With FWD_EN=0, sources always come from the register file, which returns stale values for the 2 following instructions.

ALU (all results DATA_W bits, wrap-around, no overflow trap):
- 000 add, 001 sub.
- 010 and, 011 or, 100 xor.
- 101 slt: signed compare, result 1 or 0.
- 110 sll, 111 srl: shift amount is B[$clog2(DATA_W)-1:0]; srl is logical.

Writes:
- ZERO_REG=1: a write to address 0 is dropped.
- There is one write port, so simultaneous write conflicts cannot arise.
- zero_flag updates whenever EXE/WB is loaded: zero_flag = (aluout==0) & EXE-stage valid.

Test Plan:
1. Reset: drive rst low mid-stream with 2 instructions in flight, then release. Required: wb_valid=0, wb_data=0, all registers 0 (checked via dbg), no write lands.
2. Back-to-back forwarding from EXE: r1 = r0 + 5 (imm), then r2 = r1 + r1 in the next cycle. Required: r2 = 10; with FWD_EN=0, r2 = 0.
3. Forwarding from WB plus EXE priority: r3 = 7, r3 = 9, then r4 = r3 + 0 in consecutive cycles. Required: r4 = 9 (the newer value wins).
4. ALU corners with DATA_W=32: sub 0 - 1 gives 0xFFFFFFFF; slt of 0x80000000 vs 1 gives 1; srl of 0x80000000 by 31 gives 1; sll by 33 uses a shift of 1.
5. Hold: assert hold for 3 cycles with 2 instructions in flight. Required: wb_* stay stable, no register change, and the results match the no-hold run after release.
6. Zero register: write 0x55 to r0, then read r0 via an instruction and via dbg. Required: both read 0 and no forwarding of 0x55 occurs.
